// File: rtl/ts_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ts_pkg                                                 |
// | Description : Shared constants, state encoding and helpers for the  |
// |               pseudo-TS demultiplexer.                               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package ts_pkg;

   localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
   localparam int         TS_PKT_LEN   = 188;
   localparam logic [7:0] TS_TAG_MASK  = 8'hFC;
   // Upper six bits every tagged sync byte must carry (0x44..0x47)
   localparam logic [7:0] TS_SYNC_TAG  = TS_SYNC_BYTE & TS_TAG_MASK;

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      CHECK = 2'd1,
      RUN   = 2'd2
   } ts_demux_state_t;

   // Channel index to one-hot per-channel strobe
   function automatic logic [3:0] ch_onehot(input logic [1:0] ch);
      return 4'b0001 << ch;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ts_demuxer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ts_demuxer_if                                          |
// | Description : Byte-stream bus of the pseudo-TS demultiplexer. The   |
// |               master modport drives the muxed stream and observes   |
// |               the per-channel outputs; the slave modport is the     |
// |               demultiplexer itself.                                  |
// |               Optional macro TS_DEMUX_DROP_CNT_EN adds o_drop_cnt.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface ts_demuxer_if;

   logic [7:0]  i_data;
   logic        i_d_valid;
   logic        i_p_sync;
   logic [7:0]  o_data;
   logic [3:0]  o_d_valid;
   logic [3:0]  o_p_sync;
   logic [1:0]  o_cur_ch;
   logic        o_locked;
   logic        o_pkt_err;
`ifdef TS_DEMUX_DROP_CNT_EN
   logic [63:0] o_drop_cnt;
`endif

   modport master (
      output i_data, i_d_valid, i_p_sync,
`ifdef TS_DEMUX_DROP_CNT_EN
      input  o_drop_cnt,
`endif
      input  o_data, o_d_valid, o_p_sync, o_cur_ch, o_locked, o_pkt_err
   );

   modport slave (
      input  i_data, i_d_valid, i_p_sync,
`ifdef TS_DEMUX_DROP_CNT_EN
      output o_drop_cnt,
`endif
      output o_data, o_d_valid, o_p_sync, o_cur_ch, o_locked, o_pkt_err
   );

endinterface
`default_nettype wire

// File: rtl/ts_frame_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ts_frame_tracker                                       |
// | Description : Locks to fixed-length packet framing of the tagged    |
// |               pseudo-TS stream. Holds byte counter, HUNT/CHECK/RUN  |
// |               state machine, good-packet counter and the latched    |
// |               channel; flags framing errors and which bytes are     |
// |               eligible for forwarding. LOCK_COUNT must be >= 2.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ts_frame_tracker
   import ts_pkg::*;
#(
   parameter int PKT_LEN    = TS_PKT_LEN,
   parameter int LOCK_COUNT = 3
)(
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic [7:0]  i_data,
   input  wire logic        i_valid,
   input  wire logic        i_sync,
   output ts_demux_state_t  o_state,     // registered state
   output logic             o_cnt_zero,  // current byte sits at packet offset 0
   output logic [1:0]       o_ch,        // channel latched from last sync
   output logic             o_err,       // framing error on the current byte
   output logic             o_fwd_en,    // current byte is to be forwarded
   output logic [1:0]       o_fwd_ch     // channel the forwarded byte belongs to
);

   localparam int CNT_W  = $clog2(PKT_LEN);
   localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0]  c_cnt_last  = CNT_W'(PKT_LEN - 1);
   localparam logic [GOOD_W-1:0] c_good_last = GOOD_W'(LOCK_COUNT - 1);

   ts_demux_state_t     r_state;
   ts_demux_state_t     w_nxt_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_nxt_cnt;
   logic [GOOD_W-1:0]   r_good;
   logic [GOOD_W-1:0]   w_nxt_good;
   logic [1:0]          r_ch;
   logic [1:0]          w_nxt_ch;
   logic                w_cand;
   logic                w_err;

   // A valid start byte carrying one of the four channel tags
   assign w_cand = i_valid && i_sync && ((i_data & TS_TAG_MASK) == TS_SYNC_TAG);

   // State register and framing counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= HUNT;
         r_cnt   <= '0;
         r_good  <= '0;
         r_ch    <= '0;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
         r_good  <= w_nxt_good;
         r_ch    <= w_nxt_ch;
      end
   end

   // Next-state and framing-error decode; only valid bytes move anything
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_good  = r_good;
      w_nxt_ch    = r_ch;
      w_err       = 1'b0;
      if (i_valid) begin
         case (r_state)
            HUNT: begin
               // Anything other than a tagged start is silently skipped
               if (w_cand) begin
                  w_nxt_state = CHECK;
                  w_nxt_good  = GOOD_W'(1);
                  w_nxt_cnt   = CNT_W'(1);
                  w_nxt_ch    = i_data[1:0];
               end
            end
            default: begin
               if (r_cnt == '0) begin
                  if (w_cand) begin
                     // Correctly spaced packet start
                     w_nxt_cnt = CNT_W'(1);
                     w_nxt_ch  = i_data[1:0];
                     if (r_state == CHECK) begin
                        w_nxt_good = r_good + GOOD_W'(1);
                        if (r_good == c_good_last) begin
                           w_nxt_state = RUN;
                        end
                     end
                  end else begin
                     // Long packet, missing sync or bad tag
                     w_err       = 1'b1;
                     w_nxt_state = HUNT;
                     w_nxt_good  = '0;
                     w_nxt_cnt   = '0;
                  end
               end else if (i_sync) begin
                  // Short packet: restart qualification on a usable sync
                  w_err = 1'b1;
                  if (w_cand) begin
                     w_nxt_state = CHECK;
                     w_nxt_good  = GOOD_W'(1);
                     w_nxt_cnt   = CNT_W'(1);
                     w_nxt_ch    = i_data[1:0];
                  end else begin
                     w_nxt_state = HUNT;
                     w_nxt_good  = '0;
                     w_nxt_cnt   = '0;
                  end
               end else begin
                  w_nxt_cnt = (r_cnt == c_cnt_last) ? '0 : r_cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

   assign o_state    = r_state;
   assign o_cnt_zero = (r_cnt == '0);
   assign o_ch       = r_ch;
   assign o_err      = w_err;
   // The packet that completes qualification is the first one forwarded
   assign o_fwd_en   = i_valid && !w_err && (w_nxt_state == RUN);
   assign o_fwd_ch   = w_nxt_ch;

endmodule
`default_nettype wire

// File: rtl/ts_demuxer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ts_demuxer                                             |
// | Description : Splits the four-channel pseudo-TS stream back into    |
// |               per-channel byte streams, restoring sync to 0x47.     |
// |               All outputs are registered (one cycle latency).       |
// |               Optional macro TS_DEMUX_DROP_CNT_EN adds saturating   |
// |               per-channel truncated-packet counters (o_drop_cnt).   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ts_demuxer
   import ts_pkg::*;
#(
   parameter int PKT_LEN    = TS_PKT_LEN,
   parameter int LOCK_COUNT = 3
)(
   input  wire logic   clk,
   input  wire logic   rst,
   ts_demuxer_if.slave bus
);

   ts_demux_state_t w_state;
   logic            w_cnt_zero;
   logic [1:0]      w_ch;
   logic            w_err;
   logic            w_fwd_en;
   logic [1:0]      w_fwd_ch;

   logic [7:0]      r_data;
   logic [3:0]      r_d_valid;
   logic [3:0]      r_p_sync;
   logic            r_pkt_err;

   ts_frame_tracker #(
      .PKT_LEN    (PKT_LEN),
      .LOCK_COUNT (LOCK_COUNT)
   ) u_tracker (
      .clk        (clk),
      .rst        (rst),
      .i_data     (bus.i_data),
      .i_valid    (bus.i_d_valid),
      .i_sync     (bus.i_p_sync),
      .o_state    (w_state),
      .o_cnt_zero (w_cnt_zero),
      .o_ch       (w_ch),
      .o_err      (w_err),
      .o_fwd_en   (w_fwd_en),
      .o_fwd_ch   (w_fwd_ch)
   );

   // Output stage: steer forwarded bytes, restore sync, hold data when idle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data    <= '0;
         r_d_valid <= '0;
         r_p_sync  <= '0;
         r_pkt_err <= 1'b0;
      end else begin
         r_pkt_err <= w_err;
         r_d_valid <= '0;
         r_p_sync  <= '0;
         if (w_fwd_en) begin
            // A forwarded byte at offset 0 is always an accepted sync
            r_data    <= w_cnt_zero ? TS_SYNC_BYTE : bus.i_data;
            r_d_valid <= ch_onehot(w_fwd_ch);
            r_p_sync  <= w_cnt_zero ? ch_onehot(w_fwd_ch) : 4'b0000;
         end
      end
   end

   assign bus.o_data    = r_data;
   assign bus.o_d_valid = r_d_valid;
   assign bus.o_p_sync  = r_p_sync;
   assign bus.o_pkt_err = r_pkt_err;
   // State register updates on the same edge as the output stage
   assign bus.o_locked  = (w_state == RUN);
   assign bus.o_cur_ch  = w_ch;

`ifdef TS_DEMUX_DROP_CNT_EN
   logic [3:0][15:0] r_drop;
   logic             w_trunc;

   // Truncation: framing error mid-packet while forwarding
   assign w_trunc = w_err && (w_state == RUN) && !w_cnt_zero;

   // Saturating per-channel truncated-packet counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_drop <= '0;
      end else if (w_trunc && (r_drop[w_ch] != 16'hFFFF)) begin
         r_drop[w_ch] <= r_drop[w_ch] + 16'd1;
      end
   end

   assign bus.o_drop_cnt = r_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ts_demuxer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ts_demuxer                                          |
// | Description : Self-checking bench for ts_demuxer. Packet records    |
// |               drive the stream; forwarded bytes are queued as       |
// |               expectations and matched against DUT output.          |
// |               Honours TS_DEMUX_DROP_CNT_EN.                          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_ts_demuxer;

   typedef struct {
      logic [1:0] ch;
      logic [7:0] data;
      logic       sync;
   } exp_t;

   typedef struct {
      logic [7:0] first;
      int         len;
      int         gaps;
      int         exp_fwd;
      int         exp_err;
      int         exp_locked;
   } vec_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   int   fwd_seen;
   int   err_seen;
   logic prev_locked;
   exp_t sb[$];
   vec_t vecs[19];

   ts_demuxer_if bus();

   ts_demuxer #(
      .PKT_LEN    (188),
      .LOCK_COUNT (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Output monitor: every valid output must match the head of the queue
   always @(negedge clk) begin
      if (bus.o_d_valid !== 4'b0000 && bus.o_d_valid !== 4'bxxxx) begin
         fwd_seen++;
         if (sb.size() == 0) begin
            chk("unexpected_output", 64'(bus.o_d_valid), 64'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_valid", 64'(bus.o_d_valid), 64'(4'b0001 << e.ch));
            chk("out_data", 64'(bus.o_data), 64'(e.data));
            chk("out_sync", 64'(bus.o_p_sync), e.sync ? 64'(4'b0001 << e.ch) : 64'h0);
         end
      end else if (bus.o_d_valid === 4'b0000 && bus.o_p_sync !== 4'b0000) begin
         chk("sync_without_valid", 64'(bus.o_p_sync), 64'h0);
      end
      if (bus.o_pkt_err === 1'b1) err_seen++;
      if (bus.o_locked === 1'b1 && prev_locked === 1'b0) begin
         chk("locked_rise_with_sync", 64'(bus.o_p_sync != 4'b0000), 64'h1);
      end
      prev_locked = bus.o_locked;
   end

   task automatic drive(input logic [7:0] d, input logic s, input logic v);
      @(posedge clk);
      #1;
      bus.i_data    = d;
      bus.i_p_sync  = s;
      bus.i_d_valid = v;
   endtask

   task automatic idle();
      drive(8'($urandom_range(255)), 1'b0, 1'b0);
   endtask

   // Send one packet; the first exp_fwd bytes are expected on the tagged channel
   task automatic send_pkt(input vec_t v);
      for (int b = 0; b < v.len; b++) begin
         logic [7:0] d;
         exp_t       e;
         if (v.gaps != 0 && $urandom_range(99) < 30) idle();
         d = (b == 0) ? v.first : 8'($urandom_range(255));
         drive(d, (b == 0), 1'b1);
         if (b < v.exp_fwd) begin
            e.ch   = v.first[1:0];
            e.data = (b == 0) ? 8'h47 : d;
            e.sync = (b == 0);
            sb.push_back(e);
         end
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int f0;
      int e0;
      f0 = fwd_seen;
      e0 = err_seen;
      send_pkt(v);
      idle();
      @(negedge clk);
      #1;
      chk($sformatf("pkt%0d_fwd_count", idx), 64'(fwd_seen - f0), 64'(v.exp_fwd));
      chk($sformatf("pkt%0d_err_pulses", idx), 64'(err_seen - e0), 64'(v.exp_err));
      chk($sformatf("pkt%0d_locked", idx), 64'(bus.o_locked), 64'(v.exp_locked));
      chk($sformatf("pkt%0d_queue_drained", idx), 64'(sb.size()), 64'h0);
   endtask

   initial begin
      vec_t v;
      int   f0;
      n_checks    = 0;
      n_errors    = 0;
      fwd_seen    = 0;
      err_seen    = 0;
      prev_locked = 1'b0;

      // first, len, gaps, fwd, err, locked-after
      vecs[0]  = '{8'h46, 188, 0,   0, 0, 0};  // ch2 qualify 1
      vecs[1]  = '{8'h46, 188, 0,   0, 0, 0};  // ch2 qualify 2
      vecs[2]  = '{8'h46, 188, 0, 188, 0, 1};  // locks, first forwarded
      vecs[3]  = '{8'h46, 188, 0, 188, 0, 1};
      vecs[4]  = '{8'h44, 188, 1, 188, 0, 1};  // interleaved channels with gaps
      vecs[5]  = '{8'h47, 188, 1, 188, 0, 1};
      vecs[6]  = '{8'h45, 188, 1, 188, 0, 1};
      vecs[7]  = '{8'h44, 100, 1, 100, 0, 1};  // sync + 99 payload, then cut
      vecs[8]  = '{8'h45, 188, 0,   0, 1, 0};  // early sync at cnt=100
      vecs[9]  = '{8'h45, 188, 0,   0, 0, 0};
      vecs[10] = '{8'h45, 188, 0, 188, 0, 1};  // 3rd good packet forwarded
      vecs[11] = '{8'h46, 189, 0, 188, 1, 0};  // 189th byte without sync
      vecs[12] = '{8'h46, 188, 1,   0, 0, 0};
      vecs[13] = '{8'h46, 188, 1,   0, 0, 0};
      vecs[14] = '{8'h46, 188, 1, 188, 0, 1};
      vecs[15] = '{8'h57, 188, 0,   0, 1, 0};  // bad tag at cnt=0
      vecs[16] = '{8'h45, 188, 0,   0, 0, 0};
      vecs[17] = '{8'h45, 188, 0,   0, 0, 0};
      vecs[18] = '{8'h45, 188, 1, 188, 0, 1};

      rst           = 1'b1;
      bus.i_data    = 8'h00;
      bus.i_p_sync  = 1'b0;
      bus.i_d_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_data", 64'(bus.o_data), 64'h0);
      chk("reset_valid", 64'(bus.o_d_valid), 64'h0);
      chk("reset_sync", 64'(bus.o_p_sync), 64'h0);
      chk("reset_cur_ch", 64'(bus.o_cur_ch), 64'h0);
      chk("reset_locked", 64'(bus.o_locked), 64'h0);
      chk("reset_pkt_err", 64'(bus.o_pkt_err), 64'h0);
`ifdef TS_DEMUX_DROP_CNT_EN
      chk("reset_drop_cnt", bus.o_drop_cnt, 64'h0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 19; i++) begin
         run_vec(i, vecs[i]);
`ifdef TS_DEMUX_DROP_CNT_EN
         if (i == 8 || i == 18) chk($sformatf("drop_cnt_after_pkt%0d", i), bus.o_drop_cnt, 64'h1);
`endif
      end

      // Reset in the middle of a forwarded ch3 packet (at byte 50)
      f0 = fwd_seen;
      for (int b = 0; b < 50; b++) begin
         logic [7:0] d;
         exp_t       e;
         d = (b == 0) ? 8'h47 : 8'($urandom_range(255));
         drive(d, (b == 0), 1'b1);
         e.ch   = 2'd3;
         e.data = (b == 0) ? 8'h47 : d;
         e.sync = (b == 0);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.i_data   = 8'($urandom_range(255));
      bus.i_p_sync = 1'b0;
      rst          = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_mid_valid", 64'(bus.o_d_valid), 64'h0);
      chk("rst_mid_data", 64'(bus.o_data), 64'h0);
      chk("rst_mid_sync", 64'(bus.o_p_sync), 64'h0);
      chk("rst_mid_locked", 64'(bus.o_locked), 64'h0);
      chk("rst_mid_cur_ch", 64'(bus.o_cur_ch), 64'h0);
`ifdef TS_DEMUX_DROP_CNT_EN
      chk("rst_mid_drop_cnt", bus.o_drop_cnt, 64'h0);
`endif
      @(posedge clk);
      #1;
      rst           = 1'b0;
      bus.i_d_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid_fwd_count", 64'(fwd_seen - f0), 64'd50);
      chk("rst_mid_queue_drained", 64'(sb.size()), 64'h0);

      // After reset the framer hunts again: one clean packet is not forwarded
      v = '{8'h47, 188, 0, 0, 0, 0};
      run_vec(19, v);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
